// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the CPU run controller: state encoding and the
// default parameter values used by the top level.
package run_ctrl_pkg;

  // Controller states; encodings are fixed so harness scripts can decode them.
  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'd0,
    S_RUN        = 2'd1,
    S_DONE       = 2'd2
  } state_e;

  localparam int DEF_RST_CYCLES  = 8;
  localparam int DEF_MAX_CYCLES  = 100000;
  localparam int DEF_HALT_REPEAT = 4;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_PC_W        = 32;

endpackage

// File: rtl/pc_repeat_det.sv
// Detects a core parked on one fetch PC: counts consecutive valid fetches of
// the same address and flags the fetch that brings the count to HALT_REPEAT.
// Stalled cycles (pc_valid low) neither advance nor break a repeat.
module pc_repeat_det #(
  parameter int HALT_REPEAT = 4,
  parameter int PC_W        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            pc_valid,
  input  logic [PC_W-1:0] pc,
  output logic            hit
);

  localparam int REP_W = $clog2(HALT_REPEAT + 1);

  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

  // Next repeat count and last PC; hit is taken from the updated count so the
  // halt is seen in the same cycle as the final repeated fetch.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    last_pc_d = last_pc_q;
    rep_cnt_d = rep_cnt_q;
    hit       = 1'b0;
    if (clear) begin
      // A cleared count of 0 makes the first valid fetch land on 1 whether or
      // not it matches the stale last_pc.
      rep_cnt_d = '0;
    end else if (pc_valid) begin
      last_pc_d = pc;
      rep_cnt_d = (pc == last_pc_q) ? rep_cnt_q + REP_W'(1) : REP_W'(1);
      hit       = (rep_cnt_d == REP_W'(HALT_REPEAT));
    end
  end

  // Repeat-tracking state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from pre-edge values.
      last_pc_q <= '0;
      rep_cnt_q <= '0;
    end else begin
      last_pc_q <= last_pc_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the pipelined MIPS core: holds the core in reset for
// RST_CYCLES, counts RUN cycles, and ends the run on a PC self-loop (halt)
// or when the cycle budget is spent (timeout). All outputs are registered.
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter int HALT_REPEAT = DEF_HALT_REPEAT,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PC_W        = DEF_PC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  output logic             cpu_reset,
  output logic             running,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             done,
  output logic             halted,
  output logic             timeout
);

  state_e           state_q, state_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             done_q, done_d;
  logic             halted_q, halted_d;
  logic             timeout_q, timeout_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             running_q, running_d;
  logic             det_clear;
  logic             halt_hit;

  // The detector only tracks fetches while the core actually runs.
  assign det_clear = restart || (state_q != S_RUN);

  pc_repeat_det #(
    .HALT_REPEAT (HALT_REPEAT),
    .PC_W        (PC_W)
  ) u_pc_repeat_det (
    .clk      (clk),
    .reset    (reset),
    .clear    (det_clear),
    .pc_valid (pc_valid),
    .pc       (pc),
    .hit      (halt_hit)
  );

  // Next-state, counter and flag logic; restart overrides every other event.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    done_d      = done_q;
    halted_d    = halted_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_RESET_HOLD: begin
        hold_cnt_d = hold_cnt_q + 8'd1;
        if (hold_cnt_q == 8'(RST_CYCLES - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        // Halt wins over a timeout landing in the same cycle.
        if (halt_hit) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          halted_d = 1'b1;
        end else if (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      S_DONE:  ;
      default: state_d = S_RESET_HOLD;
    endcase

    if (restart) begin
      state_d     = S_RESET_HOLD;
      hold_cnt_d  = '0;
      cycle_cnt_d = '0;
      done_d      = 1'b0;
      halted_d    = 1'b0;
      timeout_d   = 1'b0;
    end

    // Outputs are registered copies of the next state, so cpu_reset falls on
    // the same edge that enters RUN and rises again on the edge that leaves it.
    cpu_reset_d = (state_d != S_RUN);
    running_d   = (state_d == S_RUN);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RESET_HOLD;
      hold_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      done_q      <= 1'b0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      done_q      <= done_d;
      halted_q    <= halted_d;
      timeout_q   <= timeout_d;
      cpu_reset_q <= cpu_reset_d;
      running_q   <= running_d;
    end
  end

  assign cpu_reset = cpu_reset_q;
  assign running   = running_q;
  assign cycle_cnt = cycle_cnt_q;
  assign done      = done_q;
  assign halted    = halted_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl. Two instances share all inputs: dut_a has
// a 20-cycle budget, dut_b a 6-cycle budget so that the same halt sequence
// lands its 4th repeat exactly on its last budgeted cycle.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        restart;
  logic [31:0] pc;
  logic        pc_valid;

  logic        a_cpu_reset, a_running, a_done, a_halted, a_timeout;
  logic [31:0] a_cycle_cnt;
  logic        b_cpu_reset, b_running, b_done, b_halted, b_timeout;
  logic [31:0] b_cycle_cnt;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.RST_CYCLES(8), .MAX_CYCLES(20), .HALT_REPEAT(4), .CNT_W(32), .PC_W(32)) dut_a (
    .clk(clk), .reset(reset), .restart(restart), .pc(pc), .pc_valid(pc_valid),
    .cpu_reset(a_cpu_reset), .running(a_running), .cycle_cnt(a_cycle_cnt),
    .done(a_done), .halted(a_halted), .timeout(a_timeout)
  );

  cpu_run_ctrl #(.RST_CYCLES(8), .MAX_CYCLES(6), .HALT_REPEAT(4), .CNT_W(32), .PC_W(32)) dut_b (
    .clk(clk), .reset(reset), .restart(restart), .pc(pc), .pc_valid(pc_valid),
    .cpu_reset(b_cpu_reset), .running(b_running), .cycle_cnt(b_cycle_cnt),
    .done(b_done), .halted(b_halted), .timeout(b_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic valid);
    pc       = addr;
    pc_valid = valid;
    step();
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  // Count edges until dut_a reports running, bounded.
  task automatic wait_run(output int edges);
    edges = 0;
    while (!a_running && edges < 40) begin
      step();
      edges++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; restart = 1'b0; pc = '0; pc_valid = 1'b0;
    repeat (2) @(negedge clk);

    // 1. Reset values and hold timing.
    check("rst_cpu_reset", a_cpu_reset, 1);
    check("rst_running",   a_running,   0);
    check("rst_cycle_cnt", a_cycle_cnt, 0);
    check("rst_flags",     {a_done, a_halted, a_timeout}, 0);
    reset = 1'b0;
    repeat (7) step();
    check("hold_edge7_cpu_reset", a_cpu_reset, 1);
    check("hold_edge7_running",   a_running,   0);
    step();
    check("edge8_cpu_reset", a_cpu_reset, 0);
    check("edge8_running",   a_running,   1);
    check("edge8_cycle_cnt", a_cycle_cnt, 0);
    check("edge8_b_running", b_running,   1);

    // 2./5. Halt on 4th fetch of 0x3008; dut_b times out on the same cycle.
    fetch(32'h3000, 1); fetch(32'h3004, 1);
    fetch(32'h3008, 1); fetch(32'h3008, 1); fetch(32'h3008, 1);
    check("halt_pre_done",  a_done,      0);
    check("halt_pre_cycle", a_cycle_cnt, 5);
    fetch(32'h3008, 1);
    check("halt_halted",    a_halted,    1);
    check("halt_done",      a_done,      1);
    check("halt_timeout",   a_timeout,   0);
    check("halt_cycle",     a_cycle_cnt, 6);
    check("halt_running",   a_running,   0);
    check("halt_cpu_reset", a_cpu_reset, 1);
    check("simul_halted",   b_halted,    1);
    check("simul_timeout",  b_timeout,   0);
    check("simul_done",     b_done,      1);
    check("simul_cycle",    b_cycle_cnt, 6);
    pc_valid = 1'b0;
    repeat (3) step();
    check("halt_frozen_cycle",  a_cycle_cnt, 6);
    check("halt_frozen_halted", a_halted,    1);

    // 3. Stalls between repeats do not break the run of 0x3008.
    pulse_restart();
    check("restart_flags", {a_done, a_halted, a_timeout}, 0);
    check("restart_cycle", a_cycle_cnt, 0);
    wait_run(n);
    check("restart_hold_edges", n, 8);
    fetch(32'h3000, 1); fetch(32'h3004, 1);
    fetch(32'h3008, 1); fetch(32'h3008, 1);
    fetch(32'h3008, 0); fetch(32'h3008, 0);
    check("stall_not_halted", a_halted,    0);
    check("stall_cycle6",     a_cycle_cnt, 6);
    check("b_budget_timeout", b_timeout,   1);
    check("b_budget_halted",  b_halted,    0);
    fetch(32'h3008, 1);
    check("stall_3rd_not_halted", a_halted, 0);
    fetch(32'h3008, 1);
    check("stall_halted", a_halted,    1);
    check("stall_cycle",  a_cycle_cnt, 8);

    // 4. Timeout with an incrementing PC.
    pulse_restart();
    wait_run(n);
    check("to_hold_edges", n, 8);
    for (int i = 0; i < 19; i++) fetch(32'h100 + 32'(4 * i), 1);
    check("to_pre_done",  a_done,      0);
    check("to_pre_cycle", a_cycle_cnt, 19);
    fetch(32'h100 + 32'(4 * 19), 1);
    check("to_timeout",   a_timeout,   1);
    check("to_done",      a_done,      1);
    check("to_halted",    a_halted,    0);
    check("to_cycle",     a_cycle_cnt, 20);
    check("to_cpu_reset", a_cpu_reset, 1);

    // 6. Restart mid-RUN at cycle_cnt = 10.
    pulse_restart();
    wait_run(n);
    for (int i = 0; i < 10; i++) fetch(32'h200 + 32'(4 * i), 1);
    check("mid_cycle10", a_cycle_cnt, 10);
    pulse_restart();
    check("mid_restart_cycle",     a_cycle_cnt, 0);
    check("mid_restart_flags",     {a_done, a_halted, a_timeout}, 0);
    check("mid_restart_cpu_reset", a_cpu_reset, 1);
    check("mid_restart_running",   a_running,   0);
    wait_run(n);
    check("mid_restart_hold_edges", n, 8);
    fetch(32'h400, 1);
    check("mid_resume_cycle", a_cycle_cnt, 1);

    // Restart held high pins the hold counter.
    restart = 1'b1;
    repeat (12) step();
    check("held_cpu_reset", a_cpu_reset, 1);
    check("held_running",   a_running,   0);
    restart = 1'b0;
    wait_run(n);
    check("held_release_edges", n, 8);

    // Async reset clears sticky flags immediately, without a clock edge.
    fetch(32'h5, 1); fetch(32'h5, 1); fetch(32'h5, 1); fetch(32'h5, 1);
    check("pre_async_halted", a_halted, 1);
    #2 reset = 1'b1;
    #1;
    check("async_done_flags", {a_done, a_halted, a_timeout}, 0);
    check("async_done_cycle", a_cycle_cnt, 0);
    @(negedge clk);
    reset = 1'b0;

    // Async reset mid-RESET_HOLD restores the full hold length.
    repeat (3) step();
    #2 reset = 1'b1;
    #1;
    check("async_hold_cpu_reset", a_cpu_reset, 1);
    check("async_hold_running",   a_running,   0);
    @(negedge clk);
    reset = 1'b0;
    wait_run(n);
    check("async_hold_edges", n, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
